// File: rtl/pu_or1k_pfpu_i2f_pipe.sv
//==============================================================================
// Module      : pu_or1k_pfpu_i2f_pipe
// Description : Two-stage signed/unsigned integer to IEEE-754 binary32 converter
//               with rounding-mode support, stall (adv_i) and flush controls.
// Revision    : 1.0
//==============================================================================
`default_nettype none

module pu_or1k_pfpu_i2f_pipe #(
  parameter int INT_W = 32,
  parameter int LZC_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             adv_i,
  input  logic             start_i,
  input  logic             unsigned_i,
  input  logic [1:0]       rmode_i,
  input  logic [INT_W-1:0] opa_i,
  output logic             i2f_rdy_o,
  output logic [31:0]      i2f_res_o,
  output logic             i2f_inx_o
);

  // Normalised value padded below so mantissa/guard/sticky slices exist for any INT_W
  localparam int         c_EW       = INT_W + 26;
  localparam logic [7:0] c_EXP_TOP  = 8'(127 + INT_W - 1);

  localparam logic [1:0] c_RM_RNE = 2'b00;
  localparam logic [1:0] c_RM_RTZ = 2'b01;
  localparam logic [1:0] c_RM_RUP = 2'b10;
  localparam logic [1:0] c_RM_RDN = 2'b11;

  // Stage 1 combinational: sign/magnitude split and leading-zero count
  logic             w_sign;
  logic [INT_W-1:0] w_mag;
  logic [LZC_W-1:0] w_lzc;
  logic             w_zero;

  assign w_sign = ~unsigned_i & opa_i[INT_W-1];
  assign w_mag  = w_sign ? -opa_i : opa_i;
  assign w_zero = (w_mag == '0);

  always_comb begin
    w_lzc = '0;
    for (int i = 0; i < INT_W; i++) begin
      if (w_mag[i]) w_lzc = LZC_W'(INT_W - 1 - i);
    end
  end

  // Stage 1 registers
  logic             r_s1_vld;
  logic             r_s1_sign;
  logic [INT_W-1:0] r_s1_mag;
  logic [LZC_W-1:0] r_s1_lzc;
  logic             r_s1_zero;
  logic [1:0]       r_s1_rmode;

  always_ff @(posedge clk) begin
    if (adv_i && start_i && !flush_i && !rst) begin
      r_s1_sign  <= w_sign;
      r_s1_mag   <= w_mag;
      r_s1_lzc   <= w_lzc;
      r_s1_zero  <= w_zero;
      r_s1_rmode <= rmode_i;
    end
  end

  // Stage 2 combinational: normalise, round, pack
  logic [INT_W-1:0] w_norm;
  logic [c_EW-1:0]  w_ext;
  logic [23:0]      w_mant;
  logic             w_guard;
  logic             w_sticky;
  logic             w_inc;
  logic [24:0]      w_m25;
  logic             w_adj;
  logic             w_hidden;
  logic [7:0]       w_exp;
  logic [31:0]      w_res;
  logic             w_inx;

  assign w_norm   = r_s1_mag << r_s1_lzc;
  assign w_ext    = {w_norm, 26'd0};
  assign w_mant   = w_ext[c_EW-1 -: 24];
  assign w_guard  = w_ext[c_EW-25];
  assign w_sticky = |w_ext[c_EW-26:0];

  always_comb begin
    w_inc = 1'b0;
    case (r_s1_rmode)
      c_RM_RNE: w_inc = w_guard & (w_sticky | w_mant[0]);
      c_RM_RTZ: w_inc = 1'b0;
      c_RM_RUP: w_inc = ~r_s1_sign & (w_guard | w_sticky);
      c_RM_RDN: w_inc = r_s1_sign & (w_guard | w_sticky);
      default:  w_inc = 1'b0;
    endcase
  end

  // A carry out of the mantissa leaves the lower 23 bits zero, so fract needs no mux
  assign w_m25    = {1'b0, w_mant} + {24'd0, w_inc};
  assign w_adj    = w_m25[24];
  assign w_hidden = w_m25[24] | w_m25[23];
  assign w_exp    = c_EXP_TOP - 8'(r_s1_lzc) + {7'd0, w_adj};
  assign w_res    = (r_s1_zero | ~w_hidden) ? 32'h0 : {r_s1_sign, w_exp, w_m25[22:0]};
  assign w_inx    = ~r_s1_zero & (w_guard | w_sticky);

  // Valid flags and output registers
  logic        r_rdy;
  logic [31:0] r_res;
  logic        r_inx;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_vld <= 1'b0;
      r_rdy    <= 1'b0;
      r_res    <= 32'h0;
      r_inx    <= 1'b0;
    end else if (flush_i) begin
      r_s1_vld <= 1'b0;
      r_rdy    <= 1'b0;
    end else if (adv_i) begin
      r_s1_vld <= start_i;
      r_rdy    <= r_s1_vld;
      if (r_s1_vld) begin
        r_res <= w_res;
        r_inx <= w_inx;
      end
    end
  end

  assign i2f_rdy_o = r_rdy;
  assign i2f_res_o = r_res;
  assign i2f_inx_o = r_inx;

endmodule

`default_nettype wire

// File: tb/tb_pu_or1k_pfpu_i2f_pipe.sv
//==============================================================================
// Module      : tb_pu_or1k_pfpu_i2f_pipe
// Description : Self-checking bench; INT_W=32/64/16 instances share stimulus and
//               are compared against an arithmetic binary32 reference model.
// Revision    : 1.0
//==============================================================================
`default_nettype none

module tb_pu_or1k_pfpu_i2f_pipe;

  typedef struct packed {
    logic [63:0] op;
    logic        un;
    logic [1:0]  rm;
  } item_t;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        adv;
  logic        start;
  logic        uns;
  logic [1:0]  rm;
  logic [63:0] opa;

  logic        rdy32, rdy64, rdy16;
  logic [31:0] res32, res64, res16;
  logic        inx32, inx64, inx16;

  int n_checks = 0;
  int n_errors = 0;

  // Expected pipeline occupancy
  logic  m_s1_v, m_o_v;
  item_t m_s1, m_o;

  pu_or1k_pfpu_i2f_pipe #(.INT_W(32), .LZC_W(6)) u_dut32 (
    .clk(clk), .rst(rst), .flush_i(flush), .adv_i(adv), .start_i(start),
    .unsigned_i(uns), .rmode_i(rm), .opa_i(opa[31:0]),
    .i2f_rdy_o(rdy32), .i2f_res_o(res32), .i2f_inx_o(inx32)
  );

  pu_or1k_pfpu_i2f_pipe #(.INT_W(64), .LZC_W(7)) u_dut64 (
    .clk(clk), .rst(rst), .flush_i(flush), .adv_i(adv), .start_i(start),
    .unsigned_i(uns), .rmode_i(rm), .opa_i(opa),
    .i2f_rdy_o(rdy64), .i2f_res_o(res64), .i2f_inx_o(inx64)
  );

  pu_or1k_pfpu_i2f_pipe #(.INT_W(16), .LZC_W(5)) u_dut16 (
    .clk(clk), .rst(rst), .flush_i(flush), .adv_i(adv), .start_i(start),
    .unsigned_i(uns), .rmode_i(rm), .opa_i(opa[15:0]),
    .i2f_rdy_o(rdy16), .i2f_res_o(res16), .i2f_inx_o(inx16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: returns {inexact, binary32}; rounding decided from the exact remainder
  function automatic logic [32:0] ref_i2f(input logic [63:0] v, input int w,
                                           input logic un, input logic [1:0] mode);
    logic [63:0] mask, vv, mag, q, rem, half;
    logic        sign, up, inexact;
    int          e, sh;
    mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    vv   = v & mask;
    sign = !un && vv[w-1];
    mag  = sign ? ((~vv + 64'd1) & mask) : vv;
    if (mag == 64'd0) return 33'd0;
    e = 63;
    while (!mag[e]) e--;
    if (e <= 23) begin
      q    = mag << (23 - e);
      rem  = 64'd0;
      half = 64'd0;
    end else begin
      sh   = e - 23;
      q    = mag >> sh;
      rem  = mag & ((64'd1 << sh) - 64'd1);
      half = 64'd1 << (sh - 1);
    end
    inexact = (rem != 64'd0);
    case (mode)
      2'd0:    up = inexact && ((rem > half) || (rem == half && q[0]));
      2'd1:    up = 1'b0;
      2'd2:    up = inexact && !sign;
      default: up = inexact && sign;
    endcase
    q = q + {63'd0, up};
    if (q[24]) begin
      q = q >> 1;
      e++;
    end
    return {inexact, sign, 8'(e + 127), q[22:0]};
  endfunction

  // One clock: apply inputs, advance the expectation, compare outputs after the edge
  task automatic cyc(input logic st, input logic un, input logic [1:0] mode,
                     input logic [63:0] op, input logic a, input logic fl, input logic rs);
    logic [32:0] r;
    start = st; uns = un; rm = mode; opa = op; adv = a; flush = fl; rst = rs;
    @(posedge clk);
    if (rs || fl) begin
      m_s1_v = 1'b0;
      m_o_v  = 1'b0;
    end else if (a) begin
      m_o_v  = m_s1_v;
      m_o    = m_s1;
      m_s1_v = st;
      m_s1   = '{op: op, un: un, rm: mode};
    end
    #1;
    check_val("rdy32", 64'(rdy32), 64'(m_o_v));
    check_val("rdy64", 64'(rdy64), 64'(m_o_v));
    check_val("rdy16", 64'(rdy16), 64'(m_o_v));
    if (rs) begin
      check_val("rst_res32", 64'(res32), 64'd0);
      check_val("rst_inx32", 64'(inx32), 64'd0);
      check_val("rst_res64", 64'(res64), 64'd0);
      check_val("rst_res16", 64'(res16), 64'd0);
    end else if (m_o_v) begin
      r = ref_i2f(m_o.op, 32, m_o.un, m_o.rm);
      check_val("res32", 64'(res32), 64'(r[31:0]));
      check_val("inx32", 64'(inx32), 64'(r[32]));
      r = ref_i2f(m_o.op, 64, m_o.un, m_o.rm);
      check_val("res64", 64'(res64), 64'(r[31:0]));
      check_val("inx64", 64'(inx64), 64'(r[32]));
      r = ref_i2f(m_o.op, 16, m_o.un, m_o.rm);
      check_val("res16", 64'(res16), 64'(r[31:0]));
      check_val("inx16_never", 64'(inx16), 64'd0);
    end
  endtask

  task automatic directed(input logic [63:0] op, input logic un, input logic [1:0] mode,
                          input logic [31:0] exp_res, input logic exp_inx);
    cyc(1'b1, un, mode, op, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 2'd0, 64'd0, 1'b1, 1'b0, 1'b0);
    check_val("dir_rdy", 64'(rdy32), 64'd1);
    check_val("dir_res", 64'(res32), 64'(exp_res));
    check_val("dir_inx", 64'(inx32), 64'(exp_inx));
  endtask

  function automatic logic [63:0] rnd_op();
    logic [63:0] v;
    v = {$urandom, $urandom};
    case ($urandom_range(0, 3))
      0:       v = v >> $urandom_range(0, 63);
      1:       v = (64'd1 << $urandom_range(0, 63)) | (64'd1 << $urandom_range(0, 40));
      2:       v = ~(v >> $urandom_range(0, 63));
      default: ;
    endcase
    return v;
  endfunction

  initial begin
    m_s1_v = 1'b0; m_o_v = 1'b0; m_s1 = '0; m_o = '0;
    rst = 1'b1; flush = 1'b0; adv = 1'b0; start = 1'b0; uns = 1'b0; rm = 2'd0; opa = 64'd0;

    cyc(1'b0, 1'b0, 2'd0, 64'd0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 2'd0, 64'd0, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 2'd0, 64'd0, 1'b1, 1'b0, 1'b0);

    directed(64'h0000_0001, 1'b0, 2'd0, 32'h3F80_0000, 1'b0);
    directed(64'hFFFF_FFFF, 1'b0, 2'd0, 32'hBF80_0000, 1'b0);
    directed(64'h8000_0000, 1'b0, 2'd0, 32'hCF00_0000, 1'b0);
    directed(64'hFFFF_FFFF, 1'b1, 2'd0, 32'h4F80_0000, 1'b1);
    directed(64'hFFFF_FFFF, 1'b1, 2'd1, 32'h4F7F_FFFF, 1'b1);
    directed(64'h0100_0001, 1'b0, 2'd0, 32'h4B80_0000, 1'b1);
    directed(64'h0100_0001, 1'b0, 2'd2, 32'h4B80_0001, 1'b1);
    for (int m = 0; m < 4; m++) directed(64'd0, 1'b0, 2'(m), 32'h0, 1'b0);

    // Back-to-back starts with a three-cycle stall in the middle
    for (int i = 0; i < 2; i++) cyc(1'b1, 1'($urandom), 2'($urandom), rnd_op(), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'($urandom), 2'($urandom), rnd_op(), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'($urandom), 2'($urandom), rnd_op(), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) cyc(1'b0, 1'b0, 2'd0, 64'd0, 1'b1, 1'b0, 1'b0);

    // Flush with two in flight
    for (int i = 0; i < 2; i++) cyc(1'b1, 1'b0, 2'd0, rnd_op(), 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 2'd0, rnd_op(), 1'b1, 1'b1, 1'b0);
    check_val("flush_rdy", 64'(rdy32), 64'd0);
    for (int i = 0; i < 2; i++) cyc(1'b0, 1'b0, 2'd0, 64'd0, 1'b1, 1'b0, 1'b0);

    // Reset with two in flight while stalled
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 2'd3, rnd_op(), 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 2'd0, rnd_op(), 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) cyc(1'b0, 1'b0, 2'd0, 64'd0, 1'b1, 1'b0, 1'b0);

    // Randomised traffic with stalls and rare flushes
    for (int i = 0; i < 3000; i++) begin
      cyc(1'($urandom_range(0, 9) < 7), 1'($urandom), 2'($urandom), rnd_op(),
          1'($urandom_range(0, 9) < 8), 1'($urandom_range(0, 99) < 3), 1'b0);
    end
    for (int i = 0; i < 2; i++) cyc(1'b0, 1'b0, 2'd0, 64'd0, 1'b1, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
